// File: rtl/uart_tx_ctrl.sv
// UART TX sequencer: pops the FIFO, paces load/shift strobes at the baud rate, supplies parity.
// Define UART_TX_PARITY_EN for 8-data+parity+stop; otherwise the parity slot is a second stop bit (8N2).
module uart_tx_ctrl #(
  parameter int DIV_W      = 16,
  parameter int FRAME_BITS = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             parity_odd,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_data,
  output logic             fifo_rd,
  output logic             load_en,
  output logic             shift_en,
  output logic             parity_bit,
  output logic             tx_busy,
  output logic             tx_done
);

  typedef enum logic [1:0] {INIT, IDLE, SEND} state_t;

  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
  localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;

  logic             start;
  logic             tick;
  logic             last;
  logic             loading;
  logic [DIV_W-1:0] div_in;

  assign start   = tx_en && !fifo_empty;
  assign tick    = (state_q == SEND) && (baud_cnt_q == div_q - ONE);
  assign last    = (bit_cnt_q == LAST_BIT);
  assign div_in  = (baud_div == '0) ? ONE : baud_div;
  // A load happens from IDLE or at the end of a stop period, giving gapless back-to-back frames.
  assign loading = start && ((state_q == IDLE) || (tick && last));

  assign fifo_rd  = reset && loading;
  assign load_en  = reset && loading;
  assign shift_en = reset && ((state_q == INIT) || (tick && !last));
  assign tx_done  = reset && tick && last;
  assign tx_busy  = reset && (state_q == SEND);

`ifdef UART_TX_PARITY_EN
  assign parity_bit = load_en && (^fifo_data ^ parity_odd);
`else
  logic unused_parity_in;
  assign unused_parity_in = parity_odd ^ (^fifo_data);
  assign parity_bit       = load_en;
`endif

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    div_d      = div_q;
    case (state_q)
      INIT: state_d = IDLE;
      IDLE: begin
        if (start) begin
          state_d    = SEND;
          div_d      = div_in;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      SEND: begin
        baud_cnt_d = baud_cnt_q + ONE;
        if (tick) begin
          baud_cnt_d = '0;
          if (!last) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (start) begin
            div_d     = div_in;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= INIT;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      div_q      <= '0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      div_q      <= div_d;
    end
  end

endmodule
